// File: rtl/mac_pkg.sv
// Shared Q8.8 fixed-point definitions for the layer MAC neurons.
// Widths, fractional bits and the common Q8.8 constants live here.
package mac_pkg;

    localparam int DW   = 16;
    localparam int FRAC = 8;

    localparam logic [DW-1:0] Q_ONE = 16'h0100;
    localparam logic [DW-1:0] Q_MAX = 16'h7FFF;
    localparam logic [DW-1:0] Q_MIN = 16'h8000;

    typedef logic signed [DW-1:0] q8_8_t;

endpackage

// File: rtl/mac_sat.sv
// Combinational signed saturator: clamps an IW-bit two's complement value
// into OW bits. Shared by the MAC layers.
module mac_sat #(
    parameter int IW = 34,
    parameter int OW = 16
) (
    input  logic [IW-1:0] din,
    output logic [OW-1:0] dout
);

    logic [IW-OW:0] upper;

    // The value fits when every bit from the output sign bit upward agrees.
    always_comb begin
        upper = din[IW-1:OW-1];
        dout  = din[OW-1:0];
        if (!((&upper) || !(|upper))) begin
            dout = din[IW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
        end
    end

endmodule

// File: rtl/mac_lyr2.sv
// Layer-2 two-input MAC neuron: res = d1*w1 + d2*w2 + b in Q8.8, 2-stage pipeline.
// Define MAC_LYR2_RELU_EN to clamp negative results to zero after saturation.
module mac_lyr2
    import mac_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] d1,
    input  logic [DW-1:0] d2,
    input  logic [DW-1:0] w1,
    input  logic [DW-1:0] w2,
    input  logic [DW-1:0] b,
    output logic          out_valid,
    output logic [DW-1:0] res
);

    localparam int PW = 2 * DW;
    localparam int AW = 2 * DW + 2;

    logic signed [PW-1:0] p1;
    logic signed [PW-1:0] p2;
    logic signed [PW-1:0] bs;
    logic                 v1;

    logic signed [PW-1:0] bext;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] scale;
    logic        [DW-1:0] sat;
    logic        [DW-1:0] fin;

    assign bext = {{DW{b[DW-1]}}, b};

    // Stage 1: full-precision Q16.16 products and bias aligned to the same scale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p1 <= '0;
            p2 <= '0;
            bs <= '0;
            v1 <= 1'b0;
        end else begin
            p1 <= $signed(d1) * $signed(w1);
            p2 <= $signed(d2) * $signed(w2);
            bs <= bext <<< FRAC;
            v1 <= in_valid;
        end
    end

    // Two guard bits make the three-term sum exact before scaling back to Q8.8.
    always_comb begin
        acc   = {{2{p1[PW-1]}}, p1} + {{2{p2[PW-1]}}, p2} + {{2{bs[PW-1]}}, bs};
        scale = acc >>> FRAC;
    end

    mac_sat #(
        .IW (AW),
        .OW (DW)
    ) u_sat (
        .din  (scale),
        .dout (sat)
    );

`ifdef MAC_LYR2_RELU_EN
    assign fin = sat[DW-1] ? '0 : sat;
`else
    assign fin = sat;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res       <= '0;
            out_valid <= 1'b0;
        end else begin
            res       <= fin;
            out_valid <= v1;
        end
    end

endmodule

// File: tb/tb_mac_lyr2.sv
// Self-checking bench for mac_lyr2: directed vector table plus latency,
// back-to-back, and mid-flight reset sequences.
module tb_mac_lyr2;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] d1, d2, w1, w2, b;
    logic        out_valid;
    logic [15:0] res;

    int checks;
    int passes;

    typedef struct {
        logic [15:0] d1;
        logic [15:0] w1;
        logic [15:0] d2;
        logic [15:0] w2;
        logic [15:0] b;
        logic [15:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[10];

    mac_lyr2 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .d1        (d1),
        .d2        (d2),
        .w1        (w1),
        .w2        (w2),
        .b         (b),
        .out_valid (out_valid),
        .res       (res)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Signed expectation mapped through the optional ReLU stage.
    function automatic logic [15:0] post(input logic [15:0] x);
`ifdef MAC_LYR2_RELU_EN
        return x[15] ? 16'h0000 : x;
`else
        return x;
`endif
    endfunction

    task automatic applyStimulus(input logic v, input logic [15:0] a1, input logic [15:0] c1,
                                 input logic [15:0] a2, input logic [15:0] c2, input logic [15:0] bb);
        in_valid = v;
        d1 = a1;
        w1 = c1;
        d2 = a2;
        w2 = c2;
        b  = bb;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        passes = 0;

        vecs[0] = '{16'h0400, 16'h0040, 16'h0400, 16'h0040, 16'h0000, 16'h0200, "v1_basic"};
        vecs[1] = '{16'h0100, 16'h0080, 16'h0100, 16'h0080, 16'h0100, 16'h0200, "v2_bias"};
        vecs[2] = '{16'hFF00, 16'h0100, 16'h0000, 16'h0000, 16'hFF80, 16'hFE80, "v3_negative"};
        vecs[3] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, "v4_sat_pos"};
        vecs[4] = '{16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h8000, "v4_sat_neg"};
        vecs[5] = '{16'h0001, 16'h0080, 16'h0000, 16'h0000, 16'h0000, 16'h0000, "trunc_pos"};
        vecs[6] = '{16'hFFFF, 16'h0080, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, "trunc_neg"};
        vecs[7] = '{16'h8000, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF, "minxmin_sat"};
        vecs[8] = '{16'h8000, 16'h8000, 16'h8000, 16'h7FFF, 16'h0000, 16'h0080, "minxmin_exact"};
        vecs[9] = '{16'h0180, 16'hFE00, 16'h0200, 16'h0300, 16'h0040, 16'h0340, "mixed"};

        rst = 1'b1;
        applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        #12;
        checkOutput("reset_valid", {15'd0, out_valid}, 16'h0000);
        checkOutput("reset_res", res, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Single vector: exactly two edges of latency, then a bubble.
        applyStimulus(1'b1, 16'h0400, 16'h0040, 16'h0400, 16'h0040, 16'h0000);
        tick();
        checkOutput("lat_edge1_valid", {15'd0, out_valid}, 16'h0000);
        in_valid = 1'b0;
        tick();
        checkOutput("lat_edge2_valid", {15'd0, out_valid}, 16'h0001);
        checkOutput("lat_edge2_res", res, 16'h0200);
        tick();
        checkOutput("lat_bubble_valid", {15'd0, out_valid}, 16'h0000);
        checkOutput("lat_bubble_res", res, 16'h0200);

        // Table streamed back-to-back, one vector per cycle.
        for (int i = 0; i <= 10; i++) begin
            if (i < 10) begin
                applyStimulus(1'b1, vecs[i].d1, vecs[i].w1, vecs[i].d2, vecs[i].w2, vecs[i].b);
            end else begin
                applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
            end
            tick();
            if (i >= 1) begin
                checkOutput({vecs[i-1].name, "_valid"}, {15'd0, out_valid}, 16'h0001);
                checkOutput({vecs[i-1].name, "_res"}, res, post(vecs[i-1].exp));
            end
        end
        tick();
        checkOutput("stream_end_valid", {15'd0, out_valid}, 16'h0000);

        // Reset while a valid operand sits in stage 1: it must never emerge.
        applyStimulus(1'b1, 16'h0100, 16'h0080, 16'h0100, 16'h0080, 16'h0100);
        tick();
        applyStimulus(1'b1, 16'h0400, 16'h0040, 16'h0400, 16'h0040, 16'h0000);
        tick();
        checkOutput("pre_rst_res", res, 16'h0200);
        applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_async_valid", {15'd0, out_valid}, 16'h0000);
        checkOutput("rst_async_res", res, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("post_rst_valid", {15'd0, out_valid}, 16'h0000);
            checkOutput("post_rst_res", res, 16'h0000);
        end

        // Fresh operands after reset produce a result again.
        applyStimulus(1'b1, 16'h0100, 16'h0080, 16'h0100, 16'h0080, 16'h0100);
        tick();
        in_valid = 1'b0;
        tick();
        checkOutput("recover_valid", {15'd0, out_valid}, 16'h0001);
        checkOutput("recover_res", res, 16'h0200);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
